conv2d_stream: RTL and testbench

- Parametrised streaming 3x3 convolution engine. It is the next generation of the address-driven convolve top.
- Accepts a raster-order pixel stream under valid/ready, with a run-time-loadable signed kernel, scale shift and output mode.
- Emits one filtered pixel per interior window with backpressure, and pulses done at end of frame.
- Sits between the image source (RAM reader or camera stream) and the filtered-image sink.

---
 rtl/conv2d_stream_pkg.sv | 33 +++
 rtl/conv2d_stream_if.sv | 33 +++
 rtl/conv2d_stream_line_buffer.sv | 48 ++++
 rtl/conv2d_stream.sv | 149 ++++++++++++++
 tb/tb_conv2d_stream.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_stream_pkg.sv
// Shared types and helpers for the streaming 3x3 convolution engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int K_TAPS = 9;

  // The sum of nine products needs four guard bits above the product width.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 5;
  endfunction

  // Optionally fold negatives to magnitude, then clamp into [0, 2^data_w-1].
  function automatic logic [31:0] sat_abs(input logic signed [63:0] v,
                                          input logic abs_en,
                                          input int data_w);
    logic signed [63:0] m;
    logic signed [63:0] max_v;
    m     = (abs_en && (v < 0)) ? -v : v;
    max_v = (64'sd1 <<< data_w) - 64'sd1;
    if (m < 0) return '0;
    if (m > max_v) return 32'(max_v);
    return 32'(m);
  endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Control, kernel-load and pixel stream signals of the convolution engine.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready valid-ready pairs on both streams.
interface conv2d_stream_if #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 5
);
  logic               start;
  logic               mode;
  logic [SHIFT_W-1:0] shift;
  logic               k_we;
  logic [3:0]         k_addr;
  logic [COEF_W-1:0]  k_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               busy;
  logic               done;

  modport slave (
    input  start, mode, shift, k_we, k_addr, k_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );

  modport master (
    output start, mode, shift, k_we, k_addr, k_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/conv2d_stream_line_buffer.sv
// Two line memories plus the last two window columns; exposes the 3x3 window including the incoming pixel.
// Latency: window output is combinational from stored state and pix_i; state updates on en_i.
// Backpressure: holds everything while en_i is low.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic [CW-1:0]                  col_i,
  input  logic [DATA_W-1:0]              pix_i,
  output logic [K_TAPS-1:0][DATA_W-1:0]  win_o
);

  logic [DATA_W-1:0] lb0_q [IMG_W];  // previous row
  logic [DATA_W-1:0] lb1_q [IMG_W];  // two rows back
  logic [DATA_W-1:0] c1_q  [3];      // window column col-2 after the next shift
  logic [DATA_W-1:0] c2_q  [3];      // window column col-1 after the next shift
  logic [DATA_W-1:0] new_col [3];

  // Newest column: oldest row at the top, current pixel at the bottom.
  always_comb begin
    new_col[0] = lb1_q[col_i];
    new_col[1] = lb0_q[col_i];
    new_col[2] = pix_i;
    for (int r = 0; r < 3; r++) begin
      win_o[r*3 + 0] = c1_q[r];
      win_o[r*3 + 1] = c2_q[r];
      win_o[r*3 + 2] = new_col[r];
    end
  end

  // Age the line memories and slide the window by one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (en_i) begin
      lb1_q[col_i] <= lb0_q[col_i];
      lb0_q[col_i] <= pix_i;
      for (int r = 0; r < 3; r++) begin
        c1_q[r] <= c2_q[r];
        c2_q[r] <= new_col[r];
      end
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 3x3 convolution: raster pixels in, one saturated result per interior window out.
// Latency: 2 cycles from acceptance of the window-completing pixel to out_valid.
// Backpressure: out_valid & ~out_ready freezes the pipeline, counters and line buffers and drops in_ready.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int SHIFT_W = 5
) (
  input logic             clk,
  input logic             rst,
  conv2d_stream_if.slave  bus
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W);

  state_t                     state_q, state_d;
  logic [CW-1:0]              col_q, col_d;
  logic [RW-1:0]              row_q, row_d;
  logic                       mode_q, mode_d;
  logic [SHIFT_W-1:0]         shift_q, shift_d;
  logic signed [COEF_W-1:0]   coef_q [K_TAPS];
  logic signed [PROD_W-1:0]   prod_q [K_TAPS];
  logic signed [PROD_W-1:0]   prod_d [K_TAPS];
  logic                       v1_q;
  logic                       out_valid_q;
  logic [DATA_W-1:0]          out_data_q, out_data_d;
  logic signed [ACC_W-1:0]    acc, acc_sh;
  logic [K_TAPS-1:0][DATA_W-1:0] win;
  logic                       stall, in_ready, accept, last_pix, win_vld;

  assign stall    = out_valid_q & ~bus.out_ready;
  assign in_ready = (state_q == ST_RUN) & ~stall;
  assign accept   = bus.in_valid & in_ready;
  assign last_pix = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
  assign win_vld  = (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

  conv_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb (
    .clk   (clk),
    .en_i  (accept),
    .col_i (col_q),
    .pix_i (bus.in_data),
    .win_o (win)
  );

  // Frame sequencing, raster position and per-frame mode/shift capture.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_RUN;
        mode_d  = bus.mode;
        shift_d = bus.shift;
        col_d   = '0;
        row_d   = '0;
      end
      ST_RUN:   if (accept && last_pix) state_d = ST_DRAIN;
      ST_DRAIN: if (!v1_q && (!out_valid_q || bus.out_ready)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // State, counters and latched frame settings.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
    end
  end

  // Kernel is writable only while idle, and a simultaneous start wins over the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K_TAPS; i++) coef_q[i] <= '0;
    end else if ((state_q == ST_IDLE) && bus.k_we && !bus.start && (bus.k_addr < 4'd9)) begin
      coef_q[bus.k_addr] <= $signed(bus.k_data);
    end
  end

  // Stage 1 products: unsigned pixel times signed coefficient.
  always_comb begin
    for (int i = 0; i < K_TAPS; i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, win[i]})) * PROD_W'(coef_q[i]);
    end
  end

  // Stage 2 combine: accumulate, scale, fold/clamp to the pixel range.
  always_comb begin
    acc = '0;
    for (int i = 0; i < K_TAPS; i++) acc = acc + ACC_W'(prod_q[i]);
    acc_sh     = acc >>> shift_q;
    out_data_d = DATA_W'(sat_abs(64'(acc_sh), mode_q, DATA_W));
  end

  // Products are captured only for accepted pixels; acceptance already implies no stall.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K_TAPS; i++) prod_q[i] <= prod_d[i];
    end
  end

  // Pipeline valids and the output register advance together unless the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (!stall) begin
      v1_q        <= accept & win_vld;
      out_valid_q <= v1_q;
      if (v1_q) out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;
  localparam int DW = 8, KW = 8, IW = 5, IH = 4, SW = 5;
  localparam int NPIX = IW * IH;
  localparam int NOUT = (IW - 2) * (IH - 2);

  // kk: 0 identity, 1 all ones, 2 centre -1; img_kind: 0 ramp, 1 constant img_val;
  // bp: 0 always ready, 2 hold ready low 5 cycles at 2nd output; exp_c: -1 means ramp result list.
  typedef struct {
    int kk; int img_kind; int img_val; int sh; int md; int bp; int poke; int exp_c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv2d_stream_if #(.DATA_W(DW), .COEF_W(KW), .SHIFT_W(SW)) bus();
  conv2d_stream #(.DATA_W(DW), .COEF_W(KW), .IMG_W(IW), .IMG_H(IH), .SHIFT_W(SW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;
  int img[NPIX];
  int kern[9];
  int exp_o[NOUT];
  int ramp_exp[NOUT];
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: direct 3x3 sum around each interior centre pixel, then shift, fold, clamp.
  function automatic void model(input int sh, input int md);
    int s;
    for (int r = 1; r < IH - 1; r++) begin
      for (int c = 1; c < IW - 1; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            s += kern[(dr + 1) * 3 + dc + 1] * img[(r + dr) * IW + c + dc];
        s = s >>> sh;
        if (md != 0 && s < 0) s = -s;
        if (s < 0) s = 0;
        else if (s > 255) s = 255;
        exp_o[(r - 1) * (IW - 2) + c - 1] = s;
      end
    end
  endfunction

  function automatic void set_kernel(input int kk);
    for (int i = 0; i < 9; i++) kern[i] = (kk == 1) ? 1 : 0;
    if (kk == 0) kern[4] = 1;
    if (kk == 2) kern[4] = -1;
  endfunction

  task automatic load_kernel();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.k_we = 1'b1; bus.k_addr = 4'(i); bus.k_data = 8'(kern[i]);
    end
    // Out-of-range indices must not alias onto real coefficients.
    for (int i = 9; i < 16; i++) begin
      @(negedge clk);
      bus.k_we = 1'b1; bus.k_addr = 4'(i); bus.k_data = 8'h7F;
    end
    @(negedge clk);
    bus.k_we = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int sh, input int md, input int bp,
                           input bit in_rand, input bit poke);
    int pix, dones, post, cyc, acc12, first_ov, hold;
    bit held, fin;
    int got[$];
    pix = 0; dones = 0; post = 0; cyc = 0; acc12 = -1; first_ov = -1; hold = 0;
    held = 0; fin = 0;
    @(negedge clk);
    check({tag, "_idle_in_ready"}, bus.in_ready, 0);
    // Start alongside a kernel write: the write must be dropped.
    bus.start = 1'b1; bus.mode = md[0]; bus.shift = sh[SW-1:0];
    bus.k_we = 1'b1; bus.k_addr = 4'd0; bus.k_data = 8'h63;
    @(negedge clk);
    bus.start = 1'b0; bus.k_we = 1'b0;
    bus.mode = ~md[0]; bus.shift = ~sh[SW-1:0];
    check({tag, "_busy"}, bus.busy, 1);
    while (!fin && cyc < 600) begin
      if (bp == 2 && !held && bus.out_valid && got.size() == 1) begin
        hold = 5; held = 1;
      end
      bus.in_valid = (pix < NPIX) && (!in_rand || $urandom_range(0, 3) != 0);
      bus.in_data  = 8'(img[(pix < NPIX) ? pix : 0]);
      if (hold > 0) bus.out_ready = 1'b0;
      else if (bp == 1) bus.out_ready = ($urandom_range(0, 2) != 0);
      else bus.out_ready = 1'b1;
      bus.k_we   = poke && (pix == 9);
      bus.start  = poke && (pix == 9);
      bus.k_addr = 4'd4; bus.k_data = 8'd5;
      #1;
      if (hold > 0) begin
        check({tag, "_stall_in_ready"}, bus.in_ready, 0);
        check({tag, "_stall_data"}, bus.out_data, 7);
        hold--;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (pix == 12) acc12 = cyc;
        pix++;
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.out_valid && bus.out_ready) got.push_back(int'(bus.out_data));
      if (bus.done) dones++;
      if (dones > 0) begin
        post++;
        if (post >= 3) fin = 1;
      end
      cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.k_we = 1'b0; bus.start = 1'b0;
    check({tag, "_terminated"}, fin, 1);
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_busy_end"}, bus.busy, 0);
    check({tag, "_latency"}, first_ov, acc12 + 2);
    check({tag, "_count"}, got.size(), NOUT);
    for (int i = 0; i < NOUT; i++)
      check($sformatf("%s_out%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_o[i]);
  endtask

  initial begin
    int n, dones, sh, md;
    bus.start = 0; bus.mode = 0; bus.shift = '0; bus.k_we = 0; bus.k_addr = '0;
    bus.k_data = '0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
    ramp_exp = '{6, 7, 8, 11, 12, 13};

    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;

    vecs[0] = '{0, 0, 0,   0, 0, 0, 0, -1};
    vecs[1] = '{1, 1, 200, 3, 0, 0, 0, 225};
    vecs[2] = '{1, 1, 200, 0, 0, 0, 0, 255};
    vecs[3] = '{2, 1, 77,  0, 0, 0, 0, 0};
    vecs[4] = '{2, 1, 77,  0, 1, 0, 0, 77};
    vecs[5] = '{0, 0, 0,   0, 0, 2, 0, -1};
    vecs[6] = '{0, 0, 0,   0, 0, 0, 1, -1};
    for (int v = 0; v < 7; v++) begin
      set_kernel(vecs[v].kk);
      for (int i = 0; i < NPIX; i++) img[i] = (vecs[v].img_kind == 0) ? i : vecs[v].img_val;
      for (int i = 0; i < NOUT; i++) exp_o[i] = (vecs[v].exp_c < 0) ? ramp_exp[i] : vecs[v].exp_c;
      load_kernel();
      run_frame($sformatf("vec%0d", v), vecs[v].sh, vecs[v].md, vecs[v].bp, 1'b0, vecs[v].poke[0]);
    end

    // Reset in mid-frame after 7 pixels.
    set_kernel(0);
    for (int i = 0; i < NPIX; i++) img[i] = i;
    load_kernel();
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.shift = '0;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 7; c++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(img[n]); bus.out_ready = 1'b1;
      #1;
      if (bus.in_ready) n++;
      @(negedge clk);
    end
    check("abort_accepted", n, 7);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    // Coefficients were cleared: an unreloaded frame produces all zeros.
    for (int i = 0; i < 9; i++) kern[i] = 0;
    model(0, 0);
    run_frame("cleared", 0, 0, 0, 1'b0, 1'b0);
    set_kernel(0);
    load_kernel();
    for (int i = 0; i < NOUT; i++) exp_o[i] = ramp_exp[i];
    run_frame("reload", 0, 0, 0, 1'b0, 1'b0);

    // Randomised frames with input gaps and sink backpressure.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
      sh = int'($urandom_range(0, 12));
      md = int'($urandom_range(0, 1));
      load_kernel();
      model(sh, md);
      run_frame($sformatf("rand%0d", f), sh, md, 1, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
